l2_arbiter_rr: RTL

Parametrised N-port arbiter between the L1 caches (and any later requestors such as a prefetcher or victim buffer) and the single L2/memory port. It supports fixed-priority or round-robin selection and muxes the address and write data. It holds one owner per transaction and re-arbitrates back-to-back on completion without an idle bubble.

---
 rtl/lc3b_types.sv | 10 +
 rtl/rr_pick.sv | 41 ++++
 rtl/l2_arbiter_rr.sv | 134 +++++++++++++
 3 files changed

// File: rtl/lc3b_types.sv
// Shared type definitions for the L1/L2 memory-side blocks.
// Contents: arb_state_t, the two-state L2 arbiter FSM encoding.
package lc3b_types;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational requestor picker for the L2 arbiter.
// Ports:
//   pend     - per-port request vector
//   ptr      - highest-priority index (round-robin only)
//   mask_en  - drop mask_idx from consideration
//   mask_idx - index to exclude (the completing owner)
//   valid    - at least one eligible requestor
//   idx      - winning index
module rr_pick #(
    parameter int unsigned NUM_PORTS = 2,
    parameter bit          RR_MODE   = 1'b1,
    localparam int unsigned IDX_W    = $clog2(NUM_PORTS)
) (
    input  logic [NUM_PORTS-1:0] pend,
    input  logic [IDX_W-1:0]     ptr,
    input  logic                 mask_en,
    input  logic [IDX_W-1:0]     mask_idx,
    output logic                 valid,
    output logic [IDX_W-1:0]     idx
);

    logic [NUM_PORTS-1:0] mask_vec;
    logic [NUM_PORTS-1:0] cand_vec;
    logic [IDX_W-1:0]     start;

    // Scan offsets from the far end down so the smallest offset from start wins.
    always_comb begin
        mask_vec = mask_en ? (NUM_PORTS'(1) << mask_idx) : '0;
        cand_vec = pend & ~mask_vec;
        start    = RR_MODE ? ptr : '0;
        valid    = 1'b0;
        idx      = '0;
        for (int k = NUM_PORTS - 1; k >= 0; k--) begin
            if (cand_vec[IDX_W'((32'(start) + 32'(k)) % 32'(NUM_PORTS))]) begin
                valid = 1'b1;
                idx   = IDX_W'((32'(start) + 32'(k)) % 32'(NUM_PORTS));
            end
        end
    end

endmodule

// File: rtl/l2_arbiter_rr.sv
// N-port arbiter between L1-side requestors and the single L2 port.
// Holds one owner per transaction and hands off back-to-back on mem_resp.
// Ports:
//   clk, reset_n              - clock, async active-low reset
//   req_read/req_write        - per-port request levels, held until resp
//   req_addr/req_wdata        - packed per-port address / write line
//   resp, grant               - one-hot completion pulse / owner indicator
//   rdata                     - mem_rdata broadcast, qualified by resp
//   mem_read/mem_write        - owner request towards L2 (read wins)
//   mem_addr/mem_wdata        - owner address / write line
//   mem_resp/mem_rdata        - L2 completion pulse / read line
module l2_arbiter_rr
    import lc3b_types::*;
#(
    parameter int unsigned NUM_PORTS = 2,
    parameter int unsigned ADDR_W    = 16,
    parameter int unsigned LINE_W    = 128,
    parameter bit          RR_MODE   = 1'b1
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic [NUM_PORTS-1:0]        req_read,
    input  logic [NUM_PORTS-1:0]        req_write,
    input  logic [NUM_PORTS*ADDR_W-1:0] req_addr,
    input  logic [NUM_PORTS*LINE_W-1:0] req_wdata,
    output logic [NUM_PORTS-1:0]        resp,
    output logic [NUM_PORTS-1:0]        grant,
    output logic [LINE_W-1:0]           rdata,
    output logic                        mem_read,
    output logic                        mem_write,
    output logic [ADDR_W-1:0]           mem_addr,
    output logic [LINE_W-1:0]           mem_wdata,
    input  logic                        mem_resp,
    input  logic [LINE_W-1:0]           mem_rdata
);

    localparam int unsigned IDX_W = $clog2(NUM_PORTS);

    arb_state_t           state_q, state_d;
    logic [IDX_W-1:0]     owner_q, owner_d;
    logic [IDX_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [NUM_PORTS-1:0] pend;
    logic                 busy;
    logic                 pick_valid;
    logic [IDX_W-1:0]     pick_idx;
    logic [IDX_W-1:0]     pick_next;
    logic [IDX_W-1:0]     sel;

    assign pend = req_read | req_write;
    assign busy = (state_q == BUSY);

    // While busy the current owner is excluded so a completing port yields.
    rr_pick #(
        .NUM_PORTS (NUM_PORTS),
        .RR_MODE   (RR_MODE)
    ) u_pick (
        .pend     (pend),
        .ptr      (rr_ptr_q),
        .mask_en  (busy),
        .mask_idx (owner_q),
        .valid    (pick_valid),
        .idx      (pick_idx)
    );

    // Pointer moves just past the winner, wrapping at NUM_PORTS.
    assign pick_next = (pick_idx == IDX_W'(NUM_PORTS - 1)) ? '0 : pick_idx + IDX_W'(1);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            owner_q  <= '0;
            rr_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    // Next-state: arbitrate from IDLE, or re-arbitrate on completion.
    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        rr_ptr_d = rr_ptr_q;
        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    state_d  = BUSY;
                    owner_d  = pick_idx;
                    rr_ptr_d = pick_next;
                end
            end
            BUSY: begin
                if (mem_resp) begin
                    if (pick_valid) begin
                        owner_d  = pick_idx;
                        rr_ptr_d = pick_next;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output muxing; everything decodes from the registered state so reset clears it at once.
    always_comb begin
        resp      = '0;
        grant     = '0;
        rdata     = '0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        sel       = busy ? owner_q : '0;
        mem_addr  = req_addr[ADDR_W-1:0];
        mem_wdata = req_wdata[LINE_W-1:0];
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (IDX_W'(i) == sel) begin
                mem_addr  = req_addr[i*ADDR_W +: ADDR_W];
                mem_wdata = req_wdata[i*LINE_W +: LINE_W];
            end
        end
        if (busy) begin
            grant     = NUM_PORTS'(1) << owner_q;
            mem_read  = req_read[owner_q];
            mem_write = req_write[owner_q] & ~req_read[owner_q];
            if (mem_resp) begin
                resp  = NUM_PORTS'(1) << owner_q;
                rdata = mem_rdata;
            end
        end
    end

endmodule
